// File: rtl/ac_tx8.sv
// ac_tx8: serial transmitter for the 8-bit accumulator word.
// Frame = start bit (0), 8 data bits LSB first, stop bit (1); each bit
// lasts CLKS_PER_BIT clocks. busy/done handshake for polling.
module ac_tx8 #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] d_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic [CW-1:0] cnt;
  logic          done_q;
  logic          tick;

  // Last cycle of the current bit period.
  assign tick = (cnt == CNT_MAX);

  // Frame sequencer. The end of the stop bit may accept a new start
  // directly, so back-to-back frames have no extra idle cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      shreg   <= 8'h00;
      bit_idx <= 3'd0;
      cnt     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            shreg   <= d_i;
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt     <= '0;
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            cnt    <= '0;
            done_q <= 1'b1;
            if (start_i) begin
              shreg   <= d_i;
              bit_idx <= 3'd0;
              state   <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line level decoded from state so reset forces it high immediately.
  always_comb begin
    tx_o = 1'b1;
    case (state)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shreg[0];
      default: tx_o = 1'b1;
    endcase
  end

  assign busy_o = (state != S_IDLE);
  assign done_o = done_q;

endmodule

// File: tb/tb_ac_tx8.sv
// tb_ac_tx8: directed tests for ac_tx8 at CLKS_PER_BIT = 4 and 1.
module tb_ac_tx8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b1;
  logic [7:0] d = 8'hFF;
  logic       tx, busy, done;
  logic       start1 = 1'b0;
  logic [7:0] d1 = 8'h00;
  logic       tx1, busy1, done1;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [2:0] obs [0:127];

  ac_tx8 #(.CLKS_PER_BIT(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .d_i(d),
    .tx_o(tx), .busy_o(busy), .done_o(done)
  );

  ac_tx8 #(.CLKS_PER_BIT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .d_i(d1),
    .tx_o(tx1), .busy_o(busy1), .done_o(done1)
  );

  always #5 clk = ~clk;

  // Expected {tx,busy,done} for cycle c after the accepting edge of a
  // lone frame carrying byte b with n clocks per bit.
  function automatic logic [2:0] frame_exp(input logic [7:0] b, input int n, input int c);
    logic t;
    if (c < n) t = 1'b0;
    else if (c < 9 * n) t = b[(c - n) / n];
    else t = 1'b1;
    return {t, (c < 10 * n), (c == 10 * n)};
  endfunction

  // Sample each data bit mid-period starting at captured offset o.
  function automatic logic [7:0] decode(input int o, input int n);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = obs[o + (k + 1) * n + n / 2][2];
    return b;
  endfunction

  task automatic test_reset();
    total_cnt++;
    if ({tx, busy, done} !== 3'b100) $display("FAIL reset_immediate got=%b exp=100", {tx, busy, done});
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({tx, busy, done, tx1, busy1, done1} !== 6'b100100)
        $display("FAIL reset_held cyc=%0d got=%b exp=100100", i, {tx, busy, done, tx1, busy1, done1});
      else pass_cnt++;
    end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({tx, busy, done} !== 3'b100) $display("FAIL reset_after cyc=%0d got=%b exp=100", i, {tx, busy, done});
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    int bc, dc;
    bc = 0; dc = 0;
    start = 1'b1; d = 8'hCC;
    @(posedge clk); #1; start = 1'b0; d = 8'h00;
    for (int c = 0; c < 44; c++) begin
      obs[c] = {tx, busy, done};
      @(posedge clk); #1;
    end
    for (int c = 0; c < 44; c++) begin
      bc += obs[c][1]; dc += obs[c][0];
      total_cnt++;
      if (obs[c] !== frame_exp(8'hCC, 4, c))
        $display("FAIL single_cyc c=%0d got=%b exp=%b", c, obs[c], frame_exp(8'hCC, 4, c));
      else pass_cnt++;
    end
    total_cnt++;
    if (bc !== 40) $display("FAIL single_busy_len got=%0d exp=40", bc); else pass_cnt++;
    total_cnt++;
    if (dc !== 1) $display("FAIL single_done_cnt got=%0d exp=1", dc); else pass_cnt++;
    total_cnt++;
    if (decode(0, 4) !== 8'hCC) $display("FAIL single_byte got=%h exp=cc", decode(0, 4)); else pass_cnt++;
  endtask

  task automatic test_busy_reject();
    int dc;
    dc = 0;
    start = 1'b1; d = 8'hCC;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 52; c++) begin
      obs[c] = {tx, busy, done};
      if (c == 11) begin start = 1'b1; d = 8'hFF; end
      if (c == 12) start = 1'b0;
      if (c == 19) d = 8'h3C;
      @(posedge clk); #1;
    end
    for (int c = 0; c < 52; c++) begin
      dc += obs[c][0];
      total_cnt++;
      if (obs[c] !== frame_exp(8'hCC, 4, c))
        $display("FAIL reject_cyc c=%0d got=%b exp=%b", c, obs[c], frame_exp(8'hCC, 4, c));
      else pass_cnt++;
    end
    total_cnt++;
    if (decode(0, 4) !== 8'hCC) $display("FAIL reject_byte got=%h exp=cc", decode(0, 4)); else pass_cnt++;
    total_cnt++;
    if (dc !== 1) $display("FAIL reject_done_cnt got=%0d exp=1", dc); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    start = 1'b1; d = 8'h01;
    @(posedge clk); #1;
    for (int c = 0; c < 86; c++) begin
      obs[c] = {tx, busy, done};
      if (c == 39) d = 8'h80;
      if (c == 79) start = 1'b0;
      @(posedge clk); #1;
    end
    for (int c = 0; c < 86; c++) begin
      if (c < 40) e = frame_exp(8'h01, 4, c);
      else begin
        e = frame_exp(8'h80, 4, c - 40);
        if (c == 40) e[0] = 1'b1;
      end
      total_cnt++;
      if (obs[c] !== e) $display("FAIL b2b_cyc c=%0d got=%b exp=%b", c, obs[c], e);
      else pass_cnt++;
    end
    total_cnt++;
    if (decode(0, 4) !== 8'h01) $display("FAIL b2b_byte0 got=%h exp=01", decode(0, 4)); else pass_cnt++;
    total_cnt++;
    if (decode(40, 4) !== 8'h80) $display("FAIL b2b_byte1 got=%h exp=80", decode(40, 4)); else pass_cnt++;
  endtask

  task automatic test_midframe_reset();
    start = 1'b1; d = 8'hA5;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
    end
    total_cnt++;
    if ({tx, busy} !== 2'b01) $display("FAIL midrst_pre got=%b exp=01", {tx, busy}); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({tx, busy, done} !== 3'b100) $display("FAIL midrst_async got=%b exp=100", {tx, busy, done});
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({tx, busy, done} !== 3'b100) $display("FAIL midrst_hold cyc=%0d got=%b exp=100", i, {tx, busy, done});
      else pass_cnt++;
    end
    rst = 1'b0; start = 1'b1; d = 8'h55;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 44; c++) begin
      obs[c] = {tx, busy, done};
      @(posedge clk); #1;
    end
    for (int c = 0; c < 44; c++) begin
      total_cnt++;
      if (obs[c] !== frame_exp(8'h55, 4, c))
        $display("FAIL midrst_resend c=%0d got=%b exp=%b", c, obs[c], frame_exp(8'h55, 4, c));
      else pass_cnt++;
    end
    total_cnt++;
    if (decode(0, 4) !== 8'h55) $display("FAIL midrst_byte got=%h exp=55", decode(0, 4)); else pass_cnt++;
  endtask

  task automatic test_clk1();
    start1 = 1'b1; d1 = 8'h00;
    @(posedge clk); #1; start1 = 1'b0;
    for (int c = 0; c < 13; c++) begin
      obs[c] = {tx1, busy1, done1};
      @(posedge clk); #1;
    end
    for (int c = 0; c < 13; c++) begin
      total_cnt++;
      if (obs[c] !== frame_exp(8'h00, 1, c))
        $display("FAIL clk1_cyc c=%0d got=%b exp=%b", c, obs[c], frame_exp(8'h00, 1, c));
      else pass_cnt++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_busy_reject();
    test_back_to_back();
    test_midframe_reset();
    test_clk1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
